// File: rtl/math_ctrl_pkg.sv
// Shared types and constants for the sequential math controller.
//   op_e      : opcode encoding (5..7 are illegal)
//   state_e   : controller FSM states
//   RES_SCALE : result width as a multiple of the operand width
package math_ctrl_pkg;

    localparam int unsigned RES_SCALE = 2;

    typedef enum logic [2:0] {
        OP_ABS  = 3'd0,
        OP_MAX  = 3'd1,
        OP_MIN  = 3'd2,
        OP_LOG2 = 3'd3,
        OP_POW  = 3'd4
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/math_rr_arb.sv
// Two-input round-robin arbiter with a one-bit preference pointer.
//   clk, rst  : clock, synchronous active-high reset (pointer -> requester 0)
//   req       : request vector
//   adv       : a grant was consumed this cycle; pointer moves to the other input
//   gnt_c     : one-hot grant (combinational)
//   gnt_idx_c : index of the granted input (combinational)
module math_rr_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       adv,
    output logic [1:0] gnt_c,
    output logic       gnt_idx_c
);

    logic ptr_q;
    logic ptr_d;

    // Preferred input wins a tie; a lone requester is always granted.
    always_comb begin
        gnt_c     = 2'b00;
        gnt_idx_c = ptr_q;
        ptr_d     = ptr_q;
        if (req[ptr_q]) begin
            gnt_idx_c = ptr_q;
        end else if (req[~ptr_q]) begin
            gnt_idx_c = ~ptr_q;
        end
        if (|req) begin
            gnt_c[gnt_idx_c] = 1'b1;
        end
        if (adv) begin
            ptr_d = ~gnt_idx_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/math_seq_ctrl.sv
// Sequential math controller: two requesters share one iterative datapath
// (ABS, MAX, MIN, LOG2 and optionally POW), one operation in flight.
//   CLK, RST            : clock, synchronous active-high reset
//   REQ_VALID/REQ_READY : per-requester handshake (READY only in IDLE)
//   REQ_OP, REQ_X/REQ_Y : per-requester opcode and operands
//   RES_VALID/RES_READY : result handshake
//   RES_DATA/ID/ERR     : result value, issuing requester, illegal-op flag
// Build option: define MATH_SEQ_CTRL_POW_EN to implement POW; otherwise
// opcode 4 is reported as illegal and no multiplier exists.
module math_seq_ctrl
    import math_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                                CLK,
    input  logic                                RST,
    input  logic [1:0]                          REQ_VALID,
    output logic [1:0]                          REQ_READY,
    input  logic [1:0][2:0]                     REQ_OP,
    input  logic [1:0][DATA_WIDTH-1:0]          REQ_X,
    input  logic [1:0][DATA_WIDTH-1:0]          REQ_Y,
    output logic                                RES_VALID,
    input  logic                                RES_READY,
    output logic [RES_SCALE*DATA_WIDTH-1:0]     RES_DATA,
    output logic                                RES_ID,
    output logic                                RES_ERR
);

    localparam int unsigned W  = DATA_WIDTH;
    localparam int unsigned RW = RES_SCALE * DATA_WIDTH;

    state_e         state_q, state_d;
    logic [2:0]     op_q, op_d;
    logic [RW-1:0]  x_q, x_d;
    logic [W-1:0]   y_q, y_d;
    logic           id_q, id_d;
    logic [RW-1:0]  acc_q, acc_d;
    logic [W-1:0]   cnt_q, cnt_d;
    logic [RW-1:0]  res_data_q, res_data_d;
    logic           res_id_q, res_id_d;
    logic           res_err_q, res_err_d;
    logic           res_valid_q, res_valid_d;

    logic [1:0]     gnt_c;
    logic           gnt_idx_c;
    logic           xfer_c;
    logic           done_c;
    logic           err_c;
    logic [RW-1:0]  res_c;
    logic [RW-1:0]  y_ext_c;

    math_rr_arb u_arb (
        .clk       (CLK),
        .rst       (RST),
        .req       (REQ_VALID),
        .adv       (xfer_c),
        .gnt_c     (gnt_c),
        .gnt_idx_c (gnt_idx_c)
    );

    // Grant is only visible while idle and out of reset.
    assign REQ_READY = (state_q == ST_IDLE && !RST) ? gnt_c : 2'b00;
    assign xfer_c    = |(REQ_VALID & REQ_READY);

    // Next-state and datapath iteration.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        x_d         = x_q;
        y_d         = y_q;
        id_d        = id_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;
        res_err_d   = res_err_q;
        res_valid_d = res_valid_q;
        done_c      = 1'b0;
        err_c       = 1'b0;
        res_c       = '0;
        y_ext_c     = {{(RW-W){y_q[W-1]}}, y_q};

        case (state_q)
            ST_IDLE: begin
                if (xfer_c) begin
                    op_d    = REQ_OP[gnt_idx_c];
                    x_d     = {{(RW-W){REQ_X[gnt_idx_c][W-1]}}, REQ_X[gnt_idx_c]};
                    y_d     = REQ_Y[gnt_idx_c];
                    id_d    = gnt_idx_c;
                    acc_d   = RW'(1);
                    cnt_d   = '0;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                case (op_q)
                    OP_ABS: begin
                        done_c = 1'b1;
                        res_c  = x_q[RW-1] ? -x_q : x_q;
                    end
                    OP_MAX: begin
                        done_c = 1'b1;
                        res_c  = ($signed(x_q) > $signed(y_ext_c)) ? x_q : y_ext_c;
                    end
                    OP_MIN: begin
                        done_c = 1'b1;
                        res_c  = ($signed(x_q) < $signed(y_ext_c)) ? x_q : y_ext_c;
                    end
                    OP_LOG2: begin
                        // One doubling per cycle until the power reaches X.
                        if ($signed(x_q) <= $signed(RW'(1))) begin
                            done_c = 1'b1;
                        end else begin
                            acc_d = acc_q << 1;
                            cnt_d = cnt_q + W'(1);
                            if (acc_d >= x_q) begin
                                done_c = 1'b1;
                                res_c  = RW'(cnt_d);
                            end
                        end
                    end
`ifdef MATH_SEQ_CTRL_POW_EN
                    OP_POW: begin
                        // One multiply per cycle; product wraps at RW bits.
                        if (y_q == '0) begin
                            done_c = 1'b1;
                            res_c  = RW'(1);
                        end else begin
                            acc_d = acc_q * x_q;
                            cnt_d = cnt_q + W'(1);
                            if (cnt_d == y_q) begin
                                done_c = 1'b1;
                                res_c  = acc_d;
                            end
                        end
                    end
`endif
                    default: begin
                        done_c = 1'b1;
                        err_c  = 1'b1;
                    end
                endcase
                if (done_c) begin
                    state_d     = ST_DONE;
                    res_valid_d = 1'b1;
                    res_data_d  = res_c;
                    res_err_d   = err_c;
                    res_id_d    = id_q;
                end
            end
            ST_DONE: begin
                if (RES_READY) begin
                    state_d     = ST_IDLE;
                    res_valid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            x_q         <= '0;
            y_q         <= '0;
            id_q        <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            res_data_q  <= '0;
            res_id_q    <= 1'b0;
            res_err_q   <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            x_q         <= x_d;
            y_q         <= y_d;
            id_q        <= id_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
            res_err_q   <= res_err_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign RES_VALID = res_valid_q;
    assign RES_DATA  = res_data_q;
    assign RES_ID    = res_id_q;
    assign RES_ERR   = res_err_q;

endmodule

// File: tb/tb_math_seq_ctrl.sv
// Self-checking bench for math_seq_ctrl: directed scenarios plus randomized
// traffic, checked against an arithmetic reference model and a round-robin
// pointer model. Honours MATH_SEQ_CTRL_POW_EN for the expected POW behaviour.
module tb_math_seq_ctrl;

    localparam int unsigned DW = 8;
    localparam int unsigned RW = 2 * DW;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [1:0]           req_valid;
    logic [1:0]           req_ready_o;
    logic [1:0][2:0]      req_op;
    logic [1:0][DW-1:0]   req_x;
    logic [1:0][DW-1:0]   req_y;
    logic                 res_valid_o;
    logic                 res_ready;
    logic [RW-1:0]        res_data_o;
    logic                 res_id_o;
    logic                 res_err_o;

    int n_cmp = 0;
    int n_bad = 0;
    int ptr_m = 0;
    int who;

    math_seq_ctrl #(.DATA_WIDTH(DW)) dut (
        .CLK       (clk),
        .RST       (rst),
        .REQ_VALID (req_valid),
        .REQ_READY (req_ready_o),
        .REQ_OP    (req_op),
        .REQ_X     (req_x),
        .REQ_Y     (req_y),
        .RES_VALID (res_valid_o),
        .RES_READY (res_ready),
        .RES_DATA  (res_data_o),
        .RES_ID    (res_id_o),
        .RES_ERR   (res_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Reference: result, CALC cycle count and error flag from the operation rules.
    task automatic model(input logic [2:0] op, input logic [DW-1:0] x, input logic [DW-1:0] y,
                         output logic [RW-1:0] r, output int cyc, output logic err);
        int    xs;
        int    ys;
        int    a;
        longint p;
        xs  = int'($signed(x));
        ys  = int'($signed(y));
        r   = '0;
        cyc = 1;
        err = 1'b0;
        case (op)
            3'd0: r = RW'(xs < 0 ? -xs : xs);
            3'd1: r = RW'(xs > ys ? xs : ys);
            3'd2: r = RW'(xs < ys ? xs : ys);
            3'd3: begin
                if (xs > 1) begin
                    a = 0;
                    while ((1 << a) < xs) a++;
                    r   = RW'(a);
                    cyc = a;
                end
            end
`ifdef MATH_SEQ_CTRL_POW_EN
            3'd4: begin
                if (y == 0) begin
                    r = RW'(1);
                end else begin
                    p = 1;
                    for (int i = 0; i < int'(y); i++) p = (p * xs) & 64'hFFFF;
                    r   = RW'(p);
                    cyc = int'(y);
                end
            end
`endif
            default: err = 1'b1;
        endcase
    endtask

    task automatic set_req(input int i, input logic [2:0] op, input logic [DW-1:0] x, input logic [DW-1:0] y);
        req_op[i]    = op;
        req_x[i]     = x;
        req_y[i]     = y;
        req_valid[i] = 1'b1;
    endtask

    task automatic rand_req(input int i);
        logic [2:0] op;
        op = 3'($urandom_range(0, 7));
        set_req(i, op, DW'($urandom), (op == 3'd4) ? DW'($urandom_range(0, 12)) : DW'($urandom));
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 64; t++) begin
            if (|req_ready_o) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Accept one request, follow it to RES_VALID and check everything about it.
    task automatic serve(output int w);
        bit            ok;
        bit            saw;
        int            exp_w;
        int            lat;
        int            cyc;
        logic [RW-1:0] r;
        logic          err;
        logic [1:0]    exp_gnt;
        #1;
        wait_ready(ok);
        chk("grant_seen", 32'(ok), 32'd1);
        if (!ok) begin
            w = -1;
            return;
        end
        exp_w   = (req_valid == 2'b11) ? ptr_m : (req_valid[0] ? 0 : 1);
        exp_gnt = 2'b01 << exp_w;
        chk("grant", 32'(req_ready_o), 32'(exp_gnt));
        w     = req_ready_o[1] ? 1 : 0;
        ptr_m = 1 - w;
        model(req_op[w], req_x[w], req_y[w], r, cyc, err);
        lat = 0;
        saw = 1'b0;
        do begin
            tick();
            lat++;
            if (|req_ready_o) saw = 1'b1;
        end while (!res_valid_o && lat < 700);
        chk("latency", 32'(lat), 32'(cyc + 1));
        chk("busy_ready", 32'(saw), 32'd0);
        chk("data", 32'(res_data_o), 32'(r));
        chk("id", 32'(res_id_o), 32'(w));
        chk("err", 32'(res_err_o), 32'(err));
    endtask

    // Hold the result for 'stall' cycles, then consume it.
    task automatic retire(input int stall);
        logic [RW-1:0] d0;
        logic          id0;
        logic          e0;
        bit            moved;
        bit            rdy;
        d0    = res_data_o;
        id0   = res_id_o;
        e0    = res_err_o;
        moved = 1'b0;
        rdy   = 1'b0;
        for (int s = 0; s < stall; s++) begin
            tick();
            if (res_data_o !== d0 || res_id_o !== id0 || res_err_o !== e0 || !res_valid_o) moved = 1'b1;
            if (|req_ready_o) rdy = 1'b1;
        end
        if (stall > 0) begin
            chk("stall_stable", 32'(moved), 32'd0);
            chk("stall_ready", 32'(rdy), 32'd0);
        end
        res_ready = 1'b1;
        #1;
        chk("release_ready", 32'(req_ready_o), 32'd0);
        tick();
        res_ready = 1'b0;
        chk("release_valid", 32'(res_valid_o), 32'd0);
        if (|req_valid) chk("ready_next", 32'(|req_ready_o), 32'd1);
    endtask

    initial begin
        bit ok;
        bit saw;
        rst       = 1'b1;
        req_valid = 2'b00;
        req_op    = '0;
        req_x     = '0;
        req_y     = '0;
        res_ready = 1'b0;
        req_valid[0] = 1'b1;
        repeat (3) tick();
        chk("rst_valid", 32'(res_valid_o), 32'd0);
        chk("rst_data", 32'(res_data_o), 32'd0);
        chk("rst_id", 32'(res_id_o), 32'd0);
        chk("rst_err", 32'(res_err_o), 32'd0);
        chk("rst_ready", 32'(req_ready_o), 32'd0);
        req_valid = 2'b00;
        rst = 1'b0;
        ptr_m = 0;
        tick();

        // ABS of the most negative operand
        set_req(0, 3'd0, 8'h80, 8'h00);
        serve(who);
        req_valid = 2'b00;
        retire(0);

        // LOG2 on requester 1
        set_req(1, 3'd3, 8'd100, 8'h00);
        serve(who);
        req_valid = 2'b00;
        retire(0);
        set_req(1, 3'd3, 8'd1, 8'h00);
        serve(who);
        req_valid = 2'b00;
        retire(0);
        set_req(1, 3'd3, 8'hFB, 8'h00);
        serve(who);
        req_valid = 2'b00;
        retire(0);

        // POW: plain, wrapping, zero exponent
        set_req(0, 3'd4, 8'd3, 8'd4);
        serve(who);
        req_valid = 2'b00;
        retire(0);
        set_req(0, 3'd4, 8'hFE, 8'd15);
        serve(who);
        req_valid = 2'b00;
        retire(0);
        set_req(0, 3'd4, 8'd7, 8'd0);
        serve(who);
        req_valid = 2'b00;
        retire(0);

        // Both requesters held valid: results alternate between them
        set_req(0, 3'd1, 8'd5, 8'hFD);
        set_req(1, 3'd2, 8'd5, 8'hFD);
        for (int k = 0; k < 4; k++) begin
            serve(who);
            retire(0);
        end
        req_valid = 2'b00;
        tick();

        // Long consumer stall with the other requester waiting
        set_req(0, 3'd0, 8'd7, 8'h00);
        set_req(1, 3'd1, 8'h81, 8'h82);
        serve(who);
        if (who >= 0) req_valid[who] = 1'b0;
        retire(10);
        serve(who);
        req_valid = 2'b00;
        retire(0);

        // Reset in the middle of a long POW discards it
        set_req(1, 3'd4, 8'd2, 8'd200);
        #1;
        wait_ready(ok);
        chk("pre_rst_grant", 32'(ok), 32'd1);
        tick();
        req_valid = 2'b00;
        set_req(0, 3'd0, 8'd9, 8'h00);
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", 32'(res_valid_o), 32'd0);
        chk("mid_rst_data", 32'(res_data_o), 32'd0);
        chk("mid_rst_id", 32'(res_id_o), 32'd0);
        chk("mid_rst_err", 32'(res_err_o), 32'd0);
        chk("mid_rst_ready", 32'(req_ready_o), 32'd0);
        req_valid = 2'b00;
        rst = 1'b0;
        ptr_m = 0;
        saw = 1'b0;
        for (int t = 0; t < 30; t++) begin
            tick();
            if (res_valid_o) saw = 1'b1;
        end
        chk("no_stale_result", 32'(saw), 32'd0);
        set_req(0, 3'd1, 8'd1, 8'd2);
        set_req(1, 3'd2, 8'd1, 8'd2);
        serve(who);
        if (who >= 0) req_valid[who] = 1'b0;
        retire(0);
        serve(who);
        req_valid = 2'b00;
        retire(0);

        // Randomized traffic with held requests and random stalls
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < 2; i++) begin
                if (!req_valid[i] && $urandom_range(0, 1) == 1) rand_req(i);
            end
            if (req_valid == 2'b00) rand_req(int'($urandom_range(0, 1)));
            serve(who);
            if (who >= 0) req_valid[who] = 1'b0;
            retire(int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
